dac_point_sequencer: RTL and testbench

Upstream stage for the SPI master in the laser projector. Accepts galvo points (12-bit X, Y plus laser enable) over a valid/ready handshake and converts each point into two 16-bit MCP4922 command words, channel A = X and channel B = Y. It drives the SPI master's start/ctrl/din inputs and watches its status register. It owns the DAC chip-select and LDAC lines, paces output at a fixed point rate, and blanks the laser on underrun.

---
 rtl/laser_dac_pkg.sv | 56 +++++
 rtl/point_period_timer.sv | 34 +++
 rtl/dac_point_sequencer.sv | 139 +++++++++++++
 tb/tb_dac_point_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_dac_pkg.sv
// Shared definitions for the laser projector DAC path: MCP4922 word layout,
// SPI master control fields and the point sequencer state encoding.
package laser_dac_pkg;

   // MCP4922 command word bit positions
   localparam int CH_BIT     = 15;
   localparam int BUF_BIT    = 14;
   localparam int GA_N_BIT   = 13;
   localparam int SHDN_N_BIT = 12;
   localparam int DATA_W     = 12;

   // SPI master control register fields
   localparam int CTRL_WIDTH_LSB = 0;
   localparam int CTRL_WIDTH_MSB = 4;
   localparam int CTRL_DIV_LSB   = 8;
   localparam int CTRL_DIV_MSB   = 15;
   localparam logic [4:0] SPI_WORD_BITS = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_CLR,
      S_WAIT_DONE,
      S_CS_GAP,
      S_LDAC,
      S_HOLD
   } seq_state_t;

   // Part of an accepted point still needed after the X word is issued
   typedef struct packed {
      logic [DATA_W-1:0] y;
      logic              laser;
   } pending_t;

   // Unbuffered, gain 1x, output active
   function automatic logic [15:0] dac_word(input logic ch, input logic [DATA_W-1:0] data);
      logic [15:0] w;
      w              = 16'h0000;
      w[CH_BIT]      = ch;
      w[BUF_BIT]     = 1'b0;
      w[GA_N_BIT]    = 1'b1;
      w[SHDN_N_BIT]  = 1'b1;
      w[DATA_W-1:0]  = data;
      return w;
   endfunction

   function automatic logic [31:0] spi_ctrl_word(input logic [7:0] div);
      logic [31:0] c;
      c = 32'h0;
      c[CTRL_DIV_MSB:CTRL_DIV_LSB]     = div;
      c[CTRL_WIDTH_MSB:CTRL_WIDTH_LSB] = SPI_WORD_BITS;
      return c;
   endfunction

endpackage

// File: rtl/point_period_timer.sv
// Point period down-counter. Loads PERIOD-1, counts to 0 and sticks there.
// expire: count is 0. last: count is 0 or 1, i.e. the period ends this cycle
// or has already ended, so a follower state can leave one cycle early and
// land in IDLE exactly when the count reaches 0.
module point_period_timer
   import laser_dac_pkg::*;
#(
   parameter int PERIOD = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire,
   output logic last
);
   localparam int W = $clog2(PERIOD);
   localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   // reload on request, otherwise count down and hold at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= RELOAD;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expire = (cnt == '0);
   assign last   = (cnt <= W'(1));

endmodule

// File: rtl/dac_point_sequencer.sv
// Galvo point sequencer: turns each accepted (X, Y, laser) point into two
// MCP4922 words pushed through the SPI master, then strobes LDAC and updates
// the laser at a fixed point rate. Blanks the laser when no point is ready.
module dac_point_sequencer
   import laser_dac_pkg::*;
#(
   parameter logic [7:0] CLK_DIV      = 8'd4,
   parameter int         POINT_PERIOD = 2000,
   parameter int         CLR_TIMEOUT  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pt_valid,
   output logic        pt_ready,
   input  logic [11:0] pt_x,
   input  logic [11:0] pt_y,
   input  logic        pt_laser,
   output logic        spi_start,
   output logic [31:0] spi_ctrl,
   output logic [31:0] spi_din,
   input  logic [31:0] spi_status,
   output logic        dac_cs_n,
   output logic        dac_ldac_n,
   output logic        laser_en,
   output logic [15:0] underrun_cnt
);
   // WAIT_CLR lasts CLR_TIMEOUT-1 cycles, so starts repeat every CLR_TIMEOUT
   localparam int CW = (CLR_TIMEOUT > 2) ? $clog2(CLR_TIMEOUT - 1) : 1;
   localparam logic [CW-1:0] CLR_LAST = CW'(CLR_TIMEOUT - 2);

   seq_state_t    state, next_state;
   pending_t      pend;
   logic          chan;        // 0 = channel A (X) in flight, 1 = channel B (Y)
   logic          sub;         // second cycle of a two-cycle state
   logic [CW-1:0] clr_cnt;
   logic          handshake, underrun;
   logic          t_expire, t_last;
   logic          xfer_nxt, enter_ldac;
   logic          status_done;
   logic          unused_status;

   assign status_done   = spi_status[0];
   assign unused_status = ^spi_status[31:1];
   assign spi_ctrl      = spi_ctrl_word(CLK_DIV);

   assign handshake = pt_valid & pt_ready;
   // pt_ready qualifies IDLE so the cycle just after reset never counts
   assign underrun  = pt_ready & ~pt_valid & t_expire;

   point_period_timer #(.PERIOD(POINT_PERIOD)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (handshake | underrun),
      .expire (t_expire),
      .last   (t_last)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // next-state logic and the look-ahead strobes used by the output registers
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (handshake) next_state = S_LOAD;
         S_LOAD:      next_state = S_START;
         S_START:     next_state = S_WAIT_CLR;
         S_WAIT_CLR: begin
            if (!status_done)
               next_state = S_WAIT_DONE;
            else if (clr_cnt == CLR_LAST)
               next_state = S_START;
         end
         S_WAIT_DONE: if (status_done) next_state = S_CS_GAP;
         S_CS_GAP:    if (sub) next_state = chan ? S_LDAC : S_LOAD;
         S_LDAC:      if (sub) next_state = S_HOLD;
         S_HOLD:      if (t_last) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
      xfer_nxt   = (next_state == S_LOAD) || (next_state == S_START) ||
                   (next_state == S_WAIT_CLR) || (next_state == S_WAIT_DONE);
      enter_ldac = (next_state == S_LDAC) && (state != S_LDAC);
   end

   // point latch, channel select, two-cycle phase and clear-wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend    <= '0;
         chan    <= 1'b0;
         sub     <= 1'b0;
         clr_cnt <= '0;
      end else begin
         if (handshake)
            pend <= '{y: pt_y, laser: pt_laser};
         if (state == S_IDLE)
            chan <= 1'b0;
         else if (state == S_CS_GAP && sub)
            chan <= ~chan;
         sub     <= ((state == S_CS_GAP) || (state == S_LDAC)) && !sub;
         clr_cnt <= (state == S_WAIT_CLR) ? clr_cnt + 1'b1 : '0;
      end
   end

   // registered outputs, decoded from the next state so they align with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pt_ready     <= 1'b0;
         spi_start    <= 1'b0;
         spi_din      <= 32'h0;
         dac_cs_n     <= 1'b1;
         dac_ldac_n   <= 1'b1;
         laser_en     <= 1'b0;
         underrun_cnt <= 16'h0;
      end else begin
         pt_ready   <= (next_state == S_IDLE);
         spi_start  <= (next_state == S_START);
         dac_cs_n   <= ~xfer_nxt;
         dac_ldac_n <= (next_state != S_LDAC);
         // X goes straight into the data register at the handshake; Y is
         // loaded as channel A's chip-select gap ends
         if (handshake)
            spi_din <= {16'h0, dac_word(1'b0, pt_x)};
         else if (state == S_CS_GAP && sub && !chan)
            spi_din <= {16'h0, dac_word(1'b1, pend.y)};
         if (underrun)
            laser_en <= 1'b0;
         else if (enter_ldac)
            laser_en <= pend.laser;
         if (underrun && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_dac_point_sequencer.sv
// Directed bench for dac_point_sequencer. Two instances: a fast one
// (CLK_DIV=1, POINT_PERIOD=200) and a slow-SPI one (CLK_DIV=8, POINT_PERIOD=64),
// each paired with a simple SPI master status model.
module tb_dac_point_sequencer;

   localparam int WT1 = 32;   // 16 bits * 2 * CLK_DIV=1
   localparam int WT2 = 256;  // 16 bits * 2 * CLK_DIV=8

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [11:0] pt_x = 12'h0, pt_y = 12'h0;
   logic        pt_laser = 1'b0;

   logic        v1 = 1'b0, r1, st1, cs1, ld1, le1;
   logic [31:0] ctrl1, din1, stat1;
   logic [15:0] ur1;
   logic        v2 = 1'b0, r2, st2, cs2, ld2, le2;
   logic [31:0] ctrl2, din2, stat2;
   logic [15:0] ur2;

   dac_point_sequencer #(.CLK_DIV(8'd1), .POINT_PERIOD(200), .CLR_TIMEOUT(8)) dut1 (
      .clk(clk), .reset(rst), .pt_valid(v1), .pt_ready(r1), .pt_x(pt_x), .pt_y(pt_y),
      .pt_laser(pt_laser), .spi_start(st1), .spi_ctrl(ctrl1), .spi_din(din1),
      .spi_status(stat1), .dac_cs_n(cs1), .dac_ldac_n(ld1), .laser_en(le1),
      .underrun_cnt(ur1));

   dac_point_sequencer #(.CLK_DIV(8'd8), .POINT_PERIOD(64), .CLR_TIMEOUT(8)) dut2 (
      .clk(clk), .reset(rst), .pt_valid(v2), .pt_ready(r2), .pt_x(pt_x), .pt_y(pt_y),
      .pt_laser(pt_laser), .spi_start(st2), .spi_ctrl(ctrl2), .spi_din(din2),
      .spi_status(stat2), .dac_cs_n(cs2), .dac_ldac_n(ld2), .laser_en(le2),
      .underrun_cnt(ur2));

   // SPI master models: start clears done, done sets WT cycles later. No reset.
   logic busy1 = 1'b0, done1 = 1'b1, stuck1 = 1'b0;
   int   mcnt1 = 0;
   logic [31:0] acc1_word[$];
   int          acc1_cyc[$];
   assign stat1 = {31'h0, done1};
   always @(posedge clk) begin
      if (st1 && !stuck1) begin
         busy1 <= 1'b1; mcnt1 <= WT1 - 1; done1 <= 1'b0;
         acc1_word.push_back(din1); acc1_cyc.push_back(cyc);
      end else if (busy1) begin
         if (mcnt1 == 0) begin busy1 <= 1'b0; done1 <= 1'b1; end
         else mcnt1 <= mcnt1 - 1;
      end
   end

   logic busy2 = 1'b0, done2 = 1'b1;
   int   mcnt2 = 0;
   logic [31:0] acc2_word[$];
   int          acc2_cyc[$];
   assign stat2 = {31'h0, done2};
   always @(posedge clk) begin
      if (st2) begin
         busy2 <= 1'b1; mcnt2 <= WT2 - 1; done2 <= 1'b0;
         acc2_word.push_back(din2); acc2_cyc.push_back(cyc);
      end else if (busy2) begin
         if (mcnt2 == 0) begin busy2 <= 1'b0; done2 <= 1'b1; end
         else mcnt2 <= mcnt2 - 1;
      end
   end

   // Monitors sample mid-cycle
   int   st1_cyc[$], hs1_cyc[$], ld1_cyc[$], ld1_w[$];
   logic ld1_las[$];
   int   cs_bad1 = 0, rdy_bad1 = 0, run1 = 0;
   logic ldp1 = 1'b1;
   always @(negedge clk) begin
      if (st1) begin
         st1_cyc.push_back(cyc);
         if (cs1) cs_bad1 <= cs_bad1 + 1;
      end
      if (r1 && v1) hs1_cyc.push_back(cyc);
      if (r1 && (!cs1 || !ld1 || st1)) rdy_bad1 <= rdy_bad1 + 1;
      if (!ld1 && ldp1) begin ld1_cyc.push_back(cyc); ld1_las.push_back(le1); end
      if (!ld1) run1 <= run1 + 1;
      else if (!ldp1) begin ld1_w.push_back(run1); run1 <= 0; end
      ldp1 <= ld1;
   end

   int   hs2_cyc[$], ld2_cyc[$];
   logic ldp2 = 1'b1;
   always @(negedge clk) begin
      if (r2 && v2) hs2_cyc.push_back(cyc);
      if (!ld2 && ldp2) ld2_cyc.push_back(cyc);
      ldp2 <= ld2;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      acc1_word.delete(); acc1_cyc.delete(); st1_cyc.delete(); hs1_cyc.delete();
      ld1_cyc.delete(); ld1_w.delete(); ld1_las.delete();
      acc2_word.delete(); acc2_cyc.delete(); hs2_cyc.delete(); ld2_cyc.delete();
      cs_bad1 = 0; rdy_bad1 = 0;
   endtask

   task automatic test_reset();
      v1 = 1'b0; v2 = 1'b0; rst = 1'b1;
      tick(3);
      tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", r1); end
      tests++; if (st1 !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", st1); end
      tests++; if (din1 !== 32'h0) begin fails++; $display("FAIL rst_din: got %h want 0", din1); end
      tests++; if ({cs1, ld1} !== 2'b11) begin fails++; $display("FAIL rst_cs_ldac: got %b want 11", {cs1, ld1}); end
      tests++; if (le1 !== 1'b0) begin fails++; $display("FAIL rst_laser: got %b want 0", le1); end
      tests++; if (ur1 !== 16'h0) begin fails++; $display("FAIL rst_underrun: got %h want 0", ur1); end
      tests++; if (ctrl1 !== 32'h0000_0110) begin fails++; $display("FAIL ctrl_div1: got %h want 00000110", ctrl1); end
      tests++; if (ctrl2 !== 32'h0000_0810) begin fails++; $display("FAIL ctrl_div8: got %h want 00000810", ctrl2); end
      rst = 1'b0;
      tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL ready_at_release: got %b want 0", r1); end
      tick(1);
      tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL ready_first_edge: got %b want 1", r1); end
   endtask

   task automatic test_single_point();
      rst = 1'b1; pt_x = 12'h123; pt_y = 12'hABC; pt_laser = 1'b1; v1 = 1'b1;
      tick(2); clear_q(); rst = 1'b0;
      for (int i = 0; i < 10 && hs1_cyc.size() < 1; i++) tick(1);
      v1 = 1'b0;
      for (int i = 0; i < 300 && ld1_w.size() < 1; i++) tick(1);
      tests++; if (acc1_word.size() !== 2) begin fails++; $display("FAIL single_nwords: got %0d want 2", acc1_word.size()); end
      tests++; if (acc1_word[0] !== 32'h0000_3123) begin fails++; $display("FAIL single_word_a: got %h want 00003123", acc1_word[0]); end
      tests++; if (acc1_word[1] !== 32'h0000_BABC) begin fails++; $display("FAIL single_word_b: got %h want 0000babc", acc1_word[1]); end
      tests++; if (st1_cyc[0] - hs1_cyc[0] !== 2) begin fails++; $display("FAIL hs_to_start: got %0d want 2", st1_cyc[0] - hs1_cyc[0]); end
      tests++; if (st1_cyc[1] - st1_cyc[0] !== WT1 + 5) begin fails++; $display("FAIL word_spacing: got %0d want %0d", st1_cyc[1] - st1_cyc[0], WT1 + 5); end
      tests++; if (cs_bad1 !== 0) begin fails++; $display("FAIL cs_framing: got %0d starts with cs high want 0", cs_bad1); end
      tests++; if (ld1_cyc.size() !== 1 || ld1_w[0] !== 2) begin fails++; $display("FAIL ldac_pulse: got %0d pulses width %0d want 1 width 2", ld1_cyc.size(), ld1_w[0]); end
      tests++; if (ld1_las[0] !== 1'b1) begin fails++; $display("FAIL ldac_laser: got %b want 1", ld1_las[0]); end
      tests++; if (ld1_cyc[0] - acc1_cyc[1] !== WT1 + 4) begin fails++; $display("FAIL ldac_after_b: got %0d want %0d", ld1_cyc[0] - acc1_cyc[1], WT1 + 4); end
   endtask

   task automatic test_back_to_back();
      rst = 1'b1; pt_x = 12'h800; pt_y = 12'h800; pt_laser = 1'b1; v1 = 1'b1;
      tick(2); clear_q(); rst = 1'b0;
      for (int i = 0; i < 800 && ld1_cyc.size() < 3; i++) tick(1);
      v1 = 1'b0;
      tests++; if (ld1_cyc[1] - ld1_cyc[0] !== 200) begin fails++; $display("FAIL b2b_period01: got %0d want 200", ld1_cyc[1] - ld1_cyc[0]); end
      tests++; if (ld1_cyc[2] - ld1_cyc[1] !== 200) begin fails++; $display("FAIL b2b_period12: got %0d want 200", ld1_cyc[2] - ld1_cyc[1]); end
      tests++; if (rdy_bad1 !== 0) begin fails++; $display("FAIL b2b_ready_busy: got %0d cycles want 0", rdy_bad1); end
      tests++; if (acc1_word[2] !== 32'h0000_3800 || acc1_word[3] !== 32'h0000_B800) begin fails++; $display("FAIL b2b_words: got %h %h want 00003800 0000b800", acc1_word[2], acc1_word[3]); end
      tests++; if (ur1 !== 16'h0) begin fails++; $display("FAIL b2b_underrun: got %0d want 0", ur1); end
   endtask

   task automatic test_underrun();
      int h;
      rst = 1'b1; pt_x = 12'h0FF; pt_y = 12'hF00; pt_laser = 1'b1; v1 = 1'b1;
      tick(2); clear_q(); rst = 1'b0;
      for (int i = 0; i < 10 && hs1_cyc.size() < 1; i++) tick(1);
      v1 = 1'b0;
      h = hs1_cyc[0];
      for (int i = 0; i < 900 && cyc < h + 3 * 200 + 20; i++) tick(1);
      tests++; if (ur1 !== 16'd3) begin fails++; $display("FAIL underrun_count: got %0d want 3", ur1); end
      tests++; if (le1 !== 1'b0) begin fails++; $display("FAIL underrun_blank: got %b want 0", le1); end
      tests++; if (st1_cyc.size() !== 2 || ld1_cyc.size() !== 1) begin fails++; $display("FAIL underrun_no_spi: got %0d starts %0d ldac want 2 1", st1_cyc.size(), ld1_cyc.size()); end
      tests++; if (ld1_las[0] !== 1'b1) begin fails++; $display("FAIL underrun_pre_laser: got %b want 1", ld1_las[0]); end
      pt_x = 12'h456; pt_y = 12'h789; pt_laser = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 300 && hs1_cyc.size() < 2; i++) tick(1);
      v1 = 1'b0;
      for (int i = 0; i < 300 && ld1_cyc.size() < 2; i++) tick(1);
      tick(1);
      tests++; if (le1 !== 1'b1 || ld1_las[1] !== 1'b1) begin fails++; $display("FAIL underrun_restore: got %b/%b want 1/1", le1, ld1_las[1]); end
      tests++; if (acc1_word[2] !== 32'h0000_3456 || acc1_word[3] !== 32'h0000_B789) begin fails++; $display("FAIL restore_words: got %h %h want 00003456 0000b789", acc1_word[2], acc1_word[3]); end
      tests++; if (ur1 !== 16'd3) begin fails++; $display("FAIL restore_count: got %0d want 3", ur1); end
   endtask

   // Runs straight after test_underrun so laser_en is already high
   task automatic test_reset_mid();
      clear_q();
      pt_x = 12'h321; pt_y = 12'h654; pt_laser = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 300 && hs1_cyc.size() < 1; i++) tick(1);
      v1 = 1'b0;
      for (int i = 0; i < 150 && acc1_word.size() < 2; i++) tick(1);
      tick(5);
      tests++; if ({cs1, le1} !== 2'b01) begin fails++; $display("FAIL mid_pre: got cs=%b laser=%b want cs=0 laser=1", cs1, le1); end
      #2 rst = 1'b1;
      #1;
      tests++; if ({cs1, ld1, le1, r1, st1} !== 5'b11000) begin fails++; $display("FAIL mid_async: got cs,ldac,laser,ready,start=%b want 11000", {cs1, ld1, le1, r1, st1}); end
      tick(2); rst = 1'b0;
      tick(60);
      tests++; if (ld1_cyc.size() !== 0) begin fails++; $display("FAIL mid_no_ldac: got %0d pulses want 0", ld1_cyc.size()); end
      clear_q();
      pt_x = 12'hABC; pt_y = 12'h123; pt_laser = 1'b1; v1 = 1'b1;
      for (int i = 0; i < 300 && hs1_cyc.size() < 1; i++) tick(1);
      v1 = 1'b0;
      for (int i = 0; i < 300 && ld1_w.size() < 1; i++) tick(1);
      tests++; if (acc1_word[0] !== 32'h0000_3ABC || acc1_word[1] !== 32'h0000_B123) begin fails++; $display("FAIL mid_recover_words: got %h %h want 00003abc 0000b123", acc1_word[0], acc1_word[1]); end
      tests++; if (ld1_las[0] !== 1'b1 || ld1_w[0] !== 2) begin fails++; $display("FAIL mid_recover_ldac: got laser %b width %0d want 1 2", ld1_las[0], ld1_w[0]); end
   endtask

   task automatic test_clr_retry();
      rst = 1'b1; pt_x = 12'h001; pt_y = 12'hFFF; pt_laser = 1'b1; v1 = 1'b1; stuck1 = 1'b1;
      tick(2); clear_q(); rst = 1'b0;
      for (int i = 0; i < 10 && hs1_cyc.size() < 1; i++) tick(1);
      v1 = 1'b0;
      for (int i = 0; i < 10 && st1_cyc.size() < 1; i++) tick(1);
      tick(20);
      stuck1 = 1'b0;
      for (int i = 0; i < 300 && ld1_w.size() < 1; i++) tick(1);
      tests++; if (st1_cyc[1] - st1_cyc[0] !== 8 || st1_cyc[2] - st1_cyc[1] !== 8 || st1_cyc[3] - st1_cyc[2] !== 8) begin fails++; $display("FAIL retry_spacing: got %0d %0d %0d want 8 8 8", st1_cyc[1] - st1_cyc[0], st1_cyc[2] - st1_cyc[1], st1_cyc[3] - st1_cyc[2]); end
      tests++; if (st1_cyc.size() !== 5) begin fails++; $display("FAIL retry_starts: got %0d want 5", st1_cyc.size()); end
      tests++; if (acc1_word[0] !== 32'h0000_3001 || acc1_word[1] !== 32'h0000_BFFF) begin fails++; $display("FAIL retry_words: got %h %h want 00003001 0000bfff", acc1_word[0], acc1_word[1]); end
      tests++; if (ld1_w[0] !== 2 || ld1_las[0] !== 1'b1) begin fails++; $display("FAIL retry_ldac: got width %0d laser %b want 2 1", ld1_w[0], ld1_las[0]); end
   endtask

   task automatic test_slow_spi();
      rst = 1'b1; pt_x = 12'h800; pt_y = 12'h800; pt_laser = 1'b1; v2 = 1'b1;
      tick(2); clear_q(); rst = 1'b0;
      for (int i = 0; i < 1500 && ld2_cyc.size() < 2; i++) tick(1);
      v2 = 1'b0;
      tests++; if (ld2_cyc[0] - acc2_cyc[1] !== WT2 + 4 || ld2_cyc[1] - acc2_cyc[3] !== WT2 + 4) begin fails++; $display("FAIL slow_ldac_after_b: got %0d %0d want %0d", ld2_cyc[0] - acc2_cyc[1], ld2_cyc[1] - acc2_cyc[3], WT2 + 4); end
      tests++; if (hs2_cyc[1] - ld2_cyc[0] !== 3) begin fails++; $display("FAIL slow_hs_stall: got %0d want 3", hs2_cyc[1] - ld2_cyc[0]); end
      tests++; if (ur2 !== 16'h0) begin fails++; $display("FAIL slow_underrun: got %0d want 0", ur2); end
      tests++; if (acc2_word[2] !== 32'h0000_3800 || acc2_word[3] !== 32'h0000_B800 || le2 !== 1'b1) begin fails++; $display("FAIL slow_words: got %h %h laser %b want 00003800 0000b800 1", acc2_word[2], acc2_word[3], le2); end
   endtask

   initial begin
      test_reset();
      test_single_point();
      test_back_to_back();
      test_underrun();
      test_reset_mid();
      test_clr_retry();
      test_slow_spi();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
